vga_screen_scan: RTL and testbench

Display-side scanner for the 128×128 monochrome frame buffer (2048 bytes, 16 bytes per row) that the screen control stage fills through its write port. It generates 640×480@60 VGA timing from the pixel clock, reads the buffer's second port, serialises each byte into pixels, and drives sync and colour pins. The 128×128 image appears in a fixed window of the visible area; all other visible pixels are background.

---
 rtl/vga_screen_scan_if.sv | 20 ++
 rtl/vga_screen_scan.sv | 126 ++++++++++++
 tb/tb_vga_screen_scan.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vga_screen_scan_if.sv
// Frame-buffer read port and VGA pin bundle between the scanner and its surroundings.
// The scanner is the master; the RAM/monitor side uses the slave view.
interface vga_screen_scan_if;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic        frame_start;

  modport master (
    output rd_addr, hsync, vsync, rgb, frame_start,
    input  rd_data
  );

  modport slave (
    input  rd_addr, hsync, vsync, rgb, frame_start,
    output rd_data
  );
endinterface

// File: rtl/vga_screen_scan.sv
// 640x480@60 scanner showing a 128x128 monochrome frame buffer in a fixed window.
// Three-stage pipeline: counters -> address/flags -> RAM data -> registered pins.
module vga_screen_scan #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned WIN_X    = 256,
  parameter int unsigned WIN_Y    = 176,
  parameter logic [2:0]  FG       = 3'b111,
  parameter logic [2:0]  BG       = 3'b000
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_screen_scan_if.master  vga
);

  localparam logic [9:0] H_LAST     = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_LO   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_HI   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_VIS_LO   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] H_WIN_LO   = 10'(H_SYNC + H_BACK + WIN_X);
  localparam logic [9:0] H_WIN_HI   = 10'(H_SYNC + H_BACK + WIN_X + 128);
  localparam logic [9:0] V_WIN_LO   = 10'(V_SYNC + V_BACK + WIN_Y);
  localparam logic [9:0] V_WIN_HI   = 10'(V_SYNC + V_BACK + WIN_Y + 128);

  logic [9:0] h_cnt, v_cnt;
  logic       h_vis, v_vis, h_win, v_win, in_win, vis, sof;
  logic [6:0] wx, wy;

  logic [2:0] bit_s1, bit_s2;
  logic       win_s1, vis_s1, hs_s1, vs_s1, fs_s1;
  logic       win_s2, vis_s2, hs_s2, vs_s2, fs_s2;
  logic [2:0] pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign h_vis  = (h_cnt >= H_VIS_LO) && (h_cnt < H_VIS_HI);
  assign v_vis  = (v_cnt >= V_VIS_LO) && (v_cnt < V_VIS_HI);
  assign h_win  = (h_cnt >= H_WIN_LO) && (h_cnt < H_WIN_HI);
  assign v_win  = (v_cnt >= V_WIN_LO) && (v_cnt < V_WIN_HI);
  assign vis    = h_vis && v_vis;
  assign in_win = h_win && v_win;
  assign sof    = (h_cnt == H_VIS_LO) && (v_cnt == V_VIS_LO);
  assign wx     = 7'(h_cnt - H_WIN_LO);
  assign wy     = 7'(v_cnt - V_WIN_LO);

  // Stage 1: address is only updated inside the window so it holds elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.rd_addr <= '0;
      bit_s1      <= '0;
      win_s1      <= 1'b0;
      vis_s1      <= 1'b0;
      hs_s1       <= 1'b0;
      vs_s1       <= 1'b0;
      fs_s1       <= 1'b0;
    end else begin
      if (in_win) vga.rd_addr <= {wy, wx[6:3]};
      bit_s1 <= wx[2:0];
      win_s1 <= in_win;
      vis_s1 <= vis;
      hs_s1  <= (h_cnt < H_SYNC_END);
      vs_s1  <= (v_cnt < V_SYNC_END);
      fs_s1  <= sof;
    end
  end

  // Stage 2: flags wait alongside the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_s2 <= '0;
      win_s2 <= 1'b0;
      vis_s2 <= 1'b0;
      hs_s2  <= 1'b0;
      vs_s2  <= 1'b0;
      fs_s2  <= 1'b0;
    end else begin
      bit_s2 <= bit_s1;
      win_s2 <= win_s1;
      vis_s2 <= vis_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      fs_s2  <= fs_s1;
    end
  end

  // LSB of each byte is the leftmost pixel.
  always_comb begin
    pix = 3'b000;
    if (vis_s2) pix = (win_s2 && vga.rd_data[bit_s2]) ? FG : BG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.rgb         <= 3'b000;
      vga.frame_start <= 1'b0;
    end else begin
      vga.hsync       <= ~hs_s2;
      vga.vsync       <= ~vs_s2;
      vga.rgb         <= pix;
      vga.frame_start <= fs_s2;
    end
  end

endmodule

// File: tb/tb_vga_screen_scan.sv
// Bench for vga_screen_scan: a shrunken-timing instance for full-frame image checks
// and a default-timing instance for the real 800-clock line and sync edges.
module tb_vga_screen_scan;
  localparam int HS = 8, HB = 4, HA = 136, HF = 4, HT = HS + HB + HA + HF;
  localparam int VS = 2, VB = 2, VA = 130, VF = 1, VT = VS + VB + VA + VF;
  localparam int WX = 4, WY = 1;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_screen_scan_if r_if ();
  vga_screen_scan_if d_if ();

  vga_screen_scan #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .WIN_X(WX), .WIN_Y(WY), .FG(3'b111), .BG(3'b000)
  ) dut_r (.clk(clk), .rst_n(rst_n), .vga(r_if.master));

  vga_screen_scan dut_d (.clk(clk), .rst_n(rst_n), .vga(d_if.master));

  logic [7:0] mem [2048];
  always @(posedge clk) r_if.rd_data <= mem[r_if.rd_addr];
  assign d_if.rd_data = 8'h00;

  int n_chk = 0;
  int n_pass = 0;
  int e = 0;
  bit main_phase = 1'b0;
  int vs_low = 0;
  int fs_seen = 0;

  // pixel spots (h, v counter values) with expected rgb in frame 0 and frame 1
  int         sp_h  [8] = '{16, 17, 31, 32, 143, 142, 15, 144};
  int         sp_v  [8] = '{5,  5,  6,  6,  69,  69,  5,  5};
  logic [2:0] sp_f0 [8] = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [2:0] sp_f1 [8] = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
  endtask

  // {hsync, vsync, frame_start, rgb} for counter index p of the shrunken instance
  function automatic logic [5:0] exp_r(input int p);
    int h, v, x, y, wx, wy;
    logic [7:0] b;
    logic [2:0] c;
    if (p < 0) return 6'b110000;
    h = p % HT;
    v = (p / HT) % VT;
    c = 3'b000;
    if (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) begin
      x = h - (HS + HB);
      y = v - (VS + VB);
      if (x >= WX && x < WX + 128 && y >= WY && y < WY + 128) begin
        wx = x - WX;
        wy = y - WY;
        b = mem[11'(wy * 16 + wx / 8)];
        if (b[wx % 8]) c = 3'b111;
      end
    end
    return {h >= HS, v >= VS, (h == HS + HB && v == VS + VB), c};
  endfunction

  function automatic logic [5:0] exp_d(input int p);
    int h, v;
    if (p < 0) return 6'b110000;
    h = p % 800;
    v = (p / 800) % 525;
    return {h >= 96, v >= 2, (h == 144 && v == 35), 3'b000};
  endfunction

  task automatic step();
    int p, q, hp, vp, hq, vq, fr;
    @(posedge clk);
    #1;
    e++;
    p = e - 3;
    q = e - 1;
    check("r_pins", 32'({r_if.hsync, r_if.vsync, r_if.frame_start, r_if.rgb}), 32'(exp_r(p)));
    check("d_pins", 32'({d_if.hsync, d_if.vsync, d_if.frame_start, d_if.rgb}), 32'(exp_d(p)));
    if (main_phase) begin
      if (p >= 0 && p < 2 * FRAME) begin
        if (!r_if.vsync) vs_low++;
        if (r_if.frame_start) fs_seen++;
      end
      if (p >= 0) begin
        hp = p % HT;
        vp = (p / HT) % VT;
        fr = p / FRAME;
        for (int i = 0; i < 8; i++)
          if (hp == sp_h[i] && vp == sp_v[i] && fr < 2)
            check("px_spot", 32'(r_if.rgb), 32'((fr == 0) ? sp_f0[i] : sp_f1[i]));
      end
      hq = q % HT;
      vq = (q / HT) % VT;
      if (hq == 16 && vq == 5) check("addr_win0", 32'(r_if.rd_addr), 32'd0);
      if (hq == 23 && vq == 6) check("addr_16", 32'(r_if.rd_addr), 32'd16);
      if (vq == 6 && hq >= 24 && hq < 32) check("addr_17", 32'(r_if.rd_addr), 32'd17);
      if (hq == 144 && vq == 5) check("addr_hold_l0", 32'(r_if.rd_addr), 32'd15);
      if (hq == 144 && vq == 6) check("addr_hold_l1", 32'(r_if.rd_addr), 32'd31);
      if (q == FRAME) check("addr_hold_vblank", 32'(r_if.rd_addr), 32'd2047);
      case (e)
        2:     begin check("r_vs_pre", 32'(r_if.vsync), 32'd1); check("d_hs_pre", 32'(d_if.hsync), 32'd1); end
        3:     begin check("r_vs_fall", 32'(r_if.vsync), 32'd0); check("d_hs_fall", 32'(d_if.hsync), 32'd0); end
        98:    check("d_hs_last_low", 32'(d_if.hsync), 32'd0);
        99:    check("d_hs_rise", 32'(d_if.hsync), 32'd1);
        306:   check("r_vs_last_low", 32'(r_if.vsync), 32'd0);
        307:   check("r_vs_rise", 32'(r_if.vsync), 32'd1);
        623:   check("r_fs_pulse", 32'(r_if.frame_start), 32'd1);
        802:   check("d_hs_pre2", 32'(d_if.hsync), 32'd1);
        803:   check("d_hs_fall2", 32'(d_if.hsync), 32'd0);
        1602:  check("d_vs_last_low", 32'(d_if.vsync), 32'd0);
        1603:  check("d_vs_rise", 32'(d_if.vsync), 32'd1);
        28147: check("d_fs_pulse", 32'(d_if.frame_start), 32'd1);
        default: ;
      endcase
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
    mem[0]  = 8'h01;
    mem[17] = 8'h80;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_pins", 32'({r_if.hsync, r_if.vsync, r_if.frame_start, r_if.rgb}), 32'b110000);
    check("rst_r_addr", 32'(r_if.rd_addr), 32'd0);
    check("rst_d_pins", 32'({d_if.hsync, d_if.vsync, d_if.frame_start, d_if.rgb}), 32'b110000);

    @(negedge clk) rst_n = 1'b1;
    e = 0;
    repeat (41 * HT + 3) step();
    check("pre_rst_hsync", 32'(r_if.hsync), 32'd0);
    check("pre_rst_addr", 32'(r_if.rd_addr), 32'd575);

    // asynchronous reset between edges, early in line 41
    #2 rst_n = 1'b0;
    #1;
    check("midrst_r_pins", 32'({r_if.hsync, r_if.vsync, r_if.frame_start, r_if.rgb}), 32'b110000);
    check("midrst_r_addr", 32'(r_if.rd_addr), 32'd0);
    check("midrst_d_pins", 32'({d_if.hsync, d_if.vsync, d_if.frame_start, d_if.rgb}), 32'b110000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    e = 0;
    main_phase = 1'b1;
    vs_low = 0;
    fs_seen = 0;

    repeat (FRAME) step();
    for (int a = 0; a < 2048; a++) begin
      mem[a] = 8'h00;
      if (a < 16 || a >= 2032) mem[a] = 8'hFF;
      else if (a % 16 == 0)    mem[a] = 8'h01;
      else if (a % 16 == 15)   mem[a] = 8'h80;
    end
    repeat (FRAME + 3) step();

    check("vsync_low_clocks", 32'(vs_low), 32'(2 * VS * HT));
    check("frame_start_count", 32'(fs_seen), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
